dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 17 +
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_lane_align.sv | 43 ++++
 rtl/dmem_responder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DS_BYTE = 2'd0,
    DS_HALF = 2'd1,
    DS_RSVD = 2'd2,
    DS_WORD = 2'd3
  } dsize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bus between the pipeline (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_dsize;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_wr, req_dsize, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_wr, req_dsize, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: merges store data into a word and right-justifies load data.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  dsize_t      dsize,
  input  logic [1:0]  lane,
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  output logic [31:0] mergedWord,
  output logic [31:0] loadData
);

  logic [4:0]  shamt;
  logic [31:0] mask;

  // Lane 0 is the most significant byte, so the shift is (3 - lane) bytes.
  always_comb begin
    shamt      = '0;
    mask       = '0;
    mergedWord = oldWord;
    loadData   = '0;
    case (dsize)
      DS_BYTE: begin
        shamt      = {~lane, 3'b000};
        mask       = 32'h0000_00FF << shamt;
        mergedWord = (oldWord & ~mask) | ({24'h0, wdata[7:0]} << shamt);
        loadData   = {24'h0, 8'(oldWord >> shamt)};
      end
      DS_HALF: begin
        shamt      = {~lane[1], 4'b0000};
        mask       = 32'h0000_FFFF << shamt;
        mergedWord = (oldWord & ~mask) | ({16'h0, wdata[15:0]} << shamt);
        loadData   = {16'h0, 16'(oldWord >> shamt)};
      end
      DS_WORD: begin
        mergedWord = wdata;
        loadData   = oldWord;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one access in flight, response LATENCY cycles after acceptance.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned SIZE    = 16384,
  parameter int unsigned LATENCY = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW       = $clog2(SIZE);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : '0;

  state_t      state, nextState;
  logic [3:0]  cnt, cntNext;
  logic        accept, enterResp, fault;

  logic        reqWr;
  dsize_t      reqDsize;
  logic [31:0] reqAddr, reqWdata;

  logic        opWr;
  dsize_t      opDsize;
  logic [31:0] opAddr, opWdata;

  logic [31:0] respRdata;
  logic        respErr;

  logic [31:0]   mem [SIZE/4];
  logic [AW-3:0] wordIdx;
  logic [31:0]   memWord, mergedWord, loadData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          nextState = (LATENCY > 1) ? WAIT : RESP;
          cntNext   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == '0) nextState = RESP;
        else           cntNext   = cnt - 4'd1;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is the acceptance edge, so operands come straight from the bus.
  always_comb begin
    if (state == IDLE) begin
      opWr    = bus.req_wr;
      opDsize = dsize_t'(bus.req_dsize);
      opAddr  = bus.req_addr;
      opWdata = bus.req_wdata;
    end else begin
      opWr    = reqWr;
      opDsize = reqDsize;
      opAddr  = reqAddr;
      opWdata = reqWdata;
    end
  end

  assign fault = (opDsize == DS_RSVD)
               | ((opDsize == DS_HALF) & opAddr[0])
               | ((opDsize == DS_WORD) & (|opAddr[1:0]))
               | (opAddr >= 32'(SIZE));

  assign enterResp = (nextState == RESP) && (state != RESP);
  assign wordIdx   = opAddr[AW-1:2];
  assign memWord   = mem[wordIdx];

  dmem_lane_align uLaneAlign (
    .dsize      (opDsize),
    .lane       (opAddr[1:0]),
    .oldWord    (memWord),
    .wdata      (opWdata),
    .mergedWord (mergedWord),
    .loadData   (loadData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqWr     <= 1'b0;
      reqDsize  <= DS_BYTE;
      reqAddr   <= '0;
      reqWdata  <= '0;
      respRdata <= '0;
      respErr   <= 1'b0;
    end else begin
      if (accept) begin
        reqWr    <= bus.req_wr;
        reqDsize <= dsize_t'(bus.req_dsize);
        reqAddr  <= bus.req_addr;
        reqWdata <= bus.req_wdata;
      end
      if (enterResp) begin
        respRdata <= (fault || opWr) ? '0 : loadData;
        respErr   <= fault;
      end else if (state == RESP) begin
        respRdata <= '0;
        respErr   <= 1'b0;
      end
    end
  end

  // Array is deliberately outside the reset domain; a held reset still blocks the commit.
  always_ff @(posedge clk) begin
    if (enterResp && opWr && !fault && !reset) mem[wordIdx] <= mergedWord;
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.stall      = (state != IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = respRdata;
  assign bus.resp_err   = respErr;

endmodule
